secuencia_patron: RTL and testbench
===================================

Name: secuencia_patron

Overview:
- Parametrised Moore serial-pattern detector. Successor to the fixed "two or more consecutive 1s" detector.
- Pattern, length and overlap mode are programmable at run time. Has a sample enable and a saturating match counter.
- Sits between a serial bit source (UART RX bit, debounced pin, LFSR) and LED/status logic on the board designs.
- With reset-time defaults it reproduces the legacy two-consecutive-1s behaviour exactly.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width
DEF_PATTERN, 8'b0000_0011, pattern loaded at reset (low DEF_LEN bits used)
DEF_LEN, 2, pattern length loaded at reset
DEF_OVERLAP, 1, overlap mode loaded at reset
LEN_W, $clog2(MAX_LEN+1), derived localparam, not overridable

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset); one clock, reset is synchronous and active-low
cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle
cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 = first bit received, bit 0 = last
cfg_len  in  LEN_W  pattern length, valid 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed
en  in  1  sample-valid; w is consumed only when en=1
w  in  1  serial input bit
cnt_clr  in  1  clear match counter
z  out  1  Moore detect output, registered
match_cnt  out  CNT_W  saturating count of detections
cfg_err  out  1  last load had an invalid length (0 or >MAX_LEN)

Behaviour:
- Reset (reset=0 at an edge):
  - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
  - hist=0, fill=0, state=SEARCH, z=0, match_cnt=0, cfg_err=0.
- Internal registers:
  - hist[MAX_LEN-1:0]: shift register; newest bit enters hist[0].
  - fill: count of valid history bits, 0..len, saturates at len.
- FSM states: IDLE (no valid config), SEARCH, DETECT. z = (state==DETECT) only. No combinational path from w to z.
- Sample, at an edge with en=1 in SEARCH or DETECT:
  - hist_n = {hist[MAX_LEN-2:0], w}; fill_n = min(fill+1, len).
  - hit = (fill_n==len) AND (hist_n[len-1:0] == pattern[len-1:0]).
  - hit=1: state<=DETECT and match_cnt increments. If overlap=0, fill<=0 and hist is kept. If overlap=1, fill<=len.
  - hit=0: state<=SEARCH.
- Latency: z rises in the cycle right after the edge that sampled the final pattern bit, as in the legacy Moore machine.
- en=0: hist, fill, state and z all hold. DETECT persists across enable gaps.
- IDLE: samples are ignored and z=0. Only cfg_load or reset leaves IDLE.
- cfg_load=1:
  - Latch the config and clear hist and fill.
  - Valid length (1..MAX_LEN): state<=SEARCH, cfg_err<=0.
  - Invalid length: state<=IDLE, cfg_err<=1.
  - cfg_load has priority over en in the same cycle; that sample is dropped.
  - match_cnt is not affected.
- Counter:
  - Saturates at 2^CNT_W-1 and holds there.
  - cnt_clr alone gives 0.
  - cnt_clr together with a hit gives 1, so no event is lost.
- Reset has priority over everything, including mid-match. The partial history is discarded.
- len=1: every sample with w==pattern[0] is a hit. Overlap setting is irrelevant.

Decomposition:
- Package secuencia_pkg:
  - State encoding localparams: ST_IDLE=2'b00, ST_SEARCH=2'b01, ST_DETECT=2'b10.
  - Helper function for the masked compare of the low len bits.
- Sub-module contador_sat (CNT_W; inc, clr, q) for the saturating counter, reusable elsewhere.
- Shift/compare and FSM stay in the top module.

Test Plan:
- Defaults, en=1, w=0,1,1,1,0 -> z=0,0,1,1,0 in the cycle after each sample; match_cnt=2 (legacy equivalence).
- Load pattern=4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 -> z high after samples 4 and 7; match_cnt=2.
- Same stream with overlap=0 -> z high after sample 4 only; match_cnt=1.
- Pattern 11 (defaults); en toggled 1,0,0,1 with w=1 each cycle -> z rises after the 4th cycle and holds through the en=0 gaps.
- cfg_len=0 load -> cfg_err=1, z stays 0 for any input. Then load len=3, pattern=3'b101 -> cfg_err=0 and detection resumes.
- CNT_W=2, five hits -> match_cnt=3. cnt_clr together with a hit -> 1. Reset asserted mid-pattern -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/secuencia_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
package secuencia_pkg;

  // Detector FSM encoding; IDLE means no usable configuration is loaded.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_DETECT = 2'b10
  } state_e;

  // Fixed compare width for the helper; limits MAX_LEN to 32 bits.
  localparam int unsigned CMP_W = 32;

  // True when the low len bits of hist and pattern agree.
  function automatic logic patron_igual(input logic [CMP_W-1:0] hist,
                                        input logic [CMP_W-1:0] pattern,
                                        input int unsigned      len);
    logic [CMP_W-1:0] mask;
    mask = (len >= CMP_W) ? '1 : ((CMP_W'(1) << len) - CMP_W'(1));
    return ((hist ^ pattern) & mask) == '0;
  endfunction

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with clear; clear plus increment yields one.
module contador_sat #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;

  // Count events, hold at all-ones, never drop an event coinciding with clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= i_inc ? CNT_W'(1) : '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + CNT_W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/secuencia_patron.sv
// Programmable Moore serial-pattern detector with enable and match counter.
// Reset defaults reproduce the legacy "two or more consecutive 1s" detector.
module secuencia_patron
  import secuencia_pkg::*;
#(
  parameter int unsigned           MAX_LEN     = 8,
  parameter int unsigned           CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]    DEF_PATTERN = MAX_LEN'(8'b0000_0011),
  parameter int unsigned           DEF_LEN     = 2,
  parameter bit                    DEF_OVERLAP = 1'b1,
  localparam int unsigned          LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_en,
  input  logic               i_w,
  input  logic               i_cnt_clr,
  output logic               o_z,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic               o_cfg_err
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_fill;
  logic               r_overlap;
  logic               r_z;
  logic               r_cfg_err;
  state_e             r_state;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic               w_sample;
  logic               w_hit;
  logic               w_cfg_ok;

  assign w_hist_n = {r_hist[MAX_LEN-2:0], i_w};
  assign w_fill_n = (r_fill < r_len) ? r_fill + LEN_W'(1) : r_len;
  // A load in the same cycle wins; that sample is dropped.
  assign w_sample = i_en && (r_state != ST_IDLE) && !i_cfg_load;
  assign w_hit    = w_sample && (w_fill_n == r_len) &&
                    patron_igual(CMP_W'(w_hist_n), CMP_W'(r_pattern), 32'(r_len));
  assign w_cfg_ok = (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(MAX_LEN));

  // Config latch, history shift and FSM with registered detect output.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= LEN_W'(DEF_LEN);
      r_overlap <= DEF_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= ST_SEARCH;
      r_z       <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (i_cfg_load) begin
      r_pattern <= i_cfg_pattern;
      r_len     <= i_cfg_len;
      r_overlap <= i_cfg_overlap;
      r_hist    <= '0;
      r_fill    <= '0;
      r_z       <= 1'b0;
      r_state   <= w_cfg_ok ? ST_SEARCH : ST_IDLE;
      r_cfg_err <= !w_cfg_ok;
    end else if (w_sample) begin
      r_hist <= w_hist_n;
      if (w_hit) begin
        r_state <= ST_DETECT;
        r_z     <= 1'b1;
        // Non-overlapping mode restarts filling but keeps the history bits.
        r_fill  <= r_overlap ? r_len : '0;
      end else begin
        r_state <= ST_SEARCH;
        r_z     <= 1'b0;
        r_fill  <= w_fill_n;
      end
    end
  end

  contador_sat #(
    .CNT_W (CNT_W)
  ) u_contador (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_hit),
    .i_clr   (i_cnt_clr),
    .o_q     (o_match_cnt)
  );

  assign o_z       = r_z;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_secuencia_patron.sv
// Directed bench: default-width instance plus a 2-bit-counter instance on shared stimulus.
module tb_secuencia_patron;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_cfg_load;
  logic [7:0] i_cfg_pattern;
  logic [3:0] i_cfg_len;
  logic       i_cfg_overlap;
  logic       i_en;
  logic       i_w;
  logic       i_cnt_clr;
  logic       z8, z2, err8, err2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  secuencia_patron dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_cfg_load    (i_cfg_load),
    .i_cfg_pattern (i_cfg_pattern),
    .i_cfg_len     (i_cfg_len),
    .i_cfg_overlap (i_cfg_overlap),
    .i_en          (i_en),
    .i_w           (i_w),
    .i_cnt_clr     (i_cnt_clr),
    .o_z           (z8),
    .o_match_cnt   (cnt8),
    .o_cfg_err     (err8)
  );

  secuencia_patron #(
    .CNT_W (2)
  ) dut_c2 (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_cfg_load    (i_cfg_load),
    .i_cfg_pattern (i_cfg_pattern),
    .i_cfg_len     (i_cfg_len),
    .i_cfg_overlap (i_cfg_overlap),
    .i_en          (i_en),
    .i_w           (i_w),
    .i_cnt_clr     (i_cnt_clr),
    .o_z           (z2),
    .o_match_cnt   (cnt2),
    .o_cfg_err     (err2)
  );

  task automatic step(input logic en, input logic w, input logic clr);
    i_en = en; i_w = w; i_cnt_clr = clr;
    @(posedge clk); #1;
    i_en = 1'b0; i_cnt_clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                      input logic en, input logic w);
    i_cfg_load = 1'b1; i_cfg_pattern = pat; i_cfg_len = len; i_cfg_overlap = ov;
    i_en = en; i_w = w;
    @(posedge clk); #1;
    i_cfg_load = 1'b0; i_en = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b1;
    checks++; if (z8 !== 1'b0) begin errors++; $display("FAIL reset_z got=%b exp=0", z8); end
    checks++; if (cnt8 !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt8); end
    checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err8); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2 got=%0d exp=0", cnt2); end
  endtask

  task automatic test_legacy();
    logic wv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic ev [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, wv[i], 1'b0);
      checks++;
      if (z8 !== ev[i]) begin errors++; $display("FAIL legacy_z[%0d] got=%b exp=%b", i, z8, ev[i]); end
    end
    checks++; if (cnt8 !== 8'd2) begin errors++; $display("FAIL legacy_cnt got=%0d exp=2", cnt8); end
  endtask

  task automatic test_pattern(input logic ov);
    logic wv [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic ev [7];
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ov};
    load(8'b0000_1011, 4'd4, ov, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, wv[i], 1'b0);
      checks++;
      if (z8 !== ev[i]) begin
        errors++; $display("FAIL pat1011_ov%0b_z[%0d] got=%b exp=%b", ov, i, z8, ev[i]);
      end
    end
    checks++;
    if (cnt8 !== (ov ? 8'd2 : 8'd1)) begin
      errors++; $display("FAIL pat1011_ov%0b_cnt got=%0d exp=%0d", ov, cnt8, ov ? 2 : 1);
    end
  endtask

  task automatic test_enable_gap();
    logic ev [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic en [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(en[i], 1'b1, 1'b0);
      checks++;
      if (z8 !== ev[i]) begin errors++; $display("FAIL engap_z[%0d] got=%b exp=%b", i, z8, ev[i]); end
    end
    checks++; if (cnt8 !== 8'd1) begin errors++; $display("FAIL engap_cnt got=%0d exp=1", cnt8); end
  endtask

  task automatic test_cfg_err();
    logic ev [3] = '{1'b0, 1'b0, 1'b1};
    logic wv [3] = '{1'b1, 1'b0, 1'b1};
    step(1'b0, 1'b0, 1'b1);
    load(8'b0000_0001, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (err8 !== 1'b1) begin errors++; $display("FAIL len0_err got=%b exp=1", err8); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i[0], 1'b0);
      checks++; if (z8 !== 1'b0) begin errors++; $display("FAIL idle_z[%0d] got=%b exp=0", i, z8); end
    end
    load(8'b0000_0011, 4'd9, 1'b1, 1'b0, 1'b0);
    checks++; if (err8 !== 1'b1) begin errors++; $display("FAIL len9_err got=%b exp=1", err8); end
    checks++; if (cnt8 !== 8'd0) begin errors++; $display("FAIL idle_cnt got=%0d exp=0", cnt8); end
    load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0);
    checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL len3_err got=%b exp=0", err8); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, wv[i], 1'b0);
      checks++;
      if (z8 !== ev[i]) begin errors++; $display("FAIL pat101_z[%0d] got=%b exp=%b", i, z8, ev[i]); end
    end
  endtask

  task automatic test_saturation();
    load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0);
    checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got=%0d exp=3", cnt2); end
    checks++; if (cnt8 !== 8'd5) begin errors++; $display("FAIL sat_cnt8 got=%0d exp=5", cnt8); end
    step(1'b1, 1'b1, 1'b1);
    checks++; if (cnt2 !== 2'd1) begin errors++; $display("FAIL clrhit_cnt2 got=%0d exp=1", cnt2); end
    checks++; if (cnt8 !== 8'd1) begin errors++; $display("FAIL clrhit_cnt8 got=%0d exp=1", cnt8); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (cnt8 !== 8'd0) begin errors++; $display("FAIL clr_cnt8 got=%0d exp=0", cnt8); end
  endtask

  task automatic test_len1_priority();
    // Sample offered with the load must be dropped.
    load(8'b0000_0001, 4'd1, 1'b0, 1'b1, 1'b1);
    checks++; if (z8 !== 1'b0) begin errors++; $display("FAIL loadprio_z got=%b exp=0", z8); end
    checks++; if (cnt8 !== 8'd0) begin errors++; $display("FAIL loadprio_cnt got=%0d exp=0", cnt8); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (z8 !== 1'b1) begin errors++; $display("FAIL len1_a_z got=%b exp=1", z8); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (z8 !== 1'b1) begin errors++; $display("FAIL len1_b_z got=%b exp=1", z8); end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (z8 !== 1'b0) begin errors++; $display("FAIL len1_c_z got=%b exp=0", z8); end
    checks++; if (cnt8 !== 8'd2) begin errors++; $display("FAIL len1_cnt got=%0d exp=2", cnt8); end
  endtask

  task automatic test_reset_mid();
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    i_reset = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    i_reset = 1'b1;
    checks++; if (z8 !== 1'b0) begin errors++; $display("FAIL rstmid_z got=%b exp=0", z8); end
    checks++; if (cnt8 !== 8'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", cnt8); end
    checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", err8); end
    // Defaults restored: 1,1 is now a hit, old partial history is gone.
    step(1'b1, 1'b1, 1'b0);
    checks++; if (z8 !== 1'b0) begin errors++; $display("FAIL rstdef_a_z got=%b exp=0", z8); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (z8 !== 1'b1) begin errors++; $display("FAIL rstdef_b_z got=%b exp=1", z8); end
  endtask

  initial begin
    i_reset = 1'b0; i_cfg_load = 1'b0; i_cfg_pattern = '0; i_cfg_len = '0;
    i_cfg_overlap = 1'b0; i_en = 1'b0; i_w = 1'b0; i_cnt_clr = 1'b0;
    test_reset();
    test_legacy();
    test_pattern(1'b1);
    test_pattern(1'b0);
    test_enable_gap();
    test_cfg_err();
    test_saturation();
    test_len1_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
